// File: rtl/bj_pkg.sv
// Shared types, constants and helpers for the blackjack card dealer.
package bj_pkg;

    localparam int NUM_RANKS = 13;

    // Fibonacci feedback taps 8,6,5,4 expressed as a mask over lfsr[7:0].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [3:0] rank_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAW    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_EMPTY   = 2'd3
    } dealer_state_t;

    function automatic logic [3:0] card_value(input rank_t rank);
        logic [3:0] val;
        if (rank == 4'd0) begin
            val = 4'd1;
        end else if (rank <= 4'd9) begin
            val = rank + 4'd1;
        end else begin
            val = 4'd10;
        end
        return val;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bj_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on each debounced 1->0 transition.
module bj_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic       sync_a_r;
    logic       sync_b_r;
    logic       level_r;
    logic       press_r;
    logic [7:0] cnt_r;

    // Two-flop synchroniser, idling at the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= 1'b1;
            sync_b_r <= 1'b1;
        end else begin
            sync_a_r <= raw;
            sync_b_r <= sync_a_r;
        end
    end

    // Level follows the synchronised input only after DEB_CYCLES differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= 1'b1;
            cnt_r   <= 8'd0;
            press_r <= 1'b0;
        end else if (sync_b_r != level_r) begin
            if (cnt_r == 8'(DEB_CYCLES - 1)) begin
                level_r <= sync_b_r;
                cnt_r   <= 8'd0;
                press_r <= ~sync_b_r;
            end else begin
                cnt_r   <= cnt_r + 8'd1;
                press_r <= 1'b0;
            end
        end else begin
            cnt_r   <= 8'd0;
            press_r <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/bj_card_dealer.sv
// Card dealer: draws pseudo-random cards from a finite shoe on NEW_CARD
// presses and hands them to the game FSM over a valid/ready handshake.
module bj_card_dealer
    import bj_pkg::*;
#(
    parameter int         DEB_CYCLES  = 4,
    parameter int         DECK_COPIES = 4,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       SYS_CLK,
    input  logic       GEN_RES,
    input  logic       START,
    input  logic       NEW_CARD,
    input  logic       CARD_READY,
    output logic       CARD_VALID,
    output logic [3:0] CARD_VAL,
    output logic [3:0] CARD_RANK,
    output logic [6:0] CARDS_LEFT,
    output logic       DECK_EMPTY,
    output logic       SHUFFLED
);

    localparam logic [2:0] COPIES    = 3'(DECK_COPIES);
    localparam logic [6:0] SHOE_SIZE = 7'(NUM_RANKS * DECK_COPIES);

    dealer_state_t state_r;
    dealer_state_t state_s;
    logic [7:0]    lfsr_r;
    logic [2:0]    cnt_r [NUM_RANKS];
    logic [6:0]    left_r;
    rank_t         rank_r;
    logic [3:0]    val_r;
    logic          shuffled_r;
    logic          start_press_s;
    logic          new_press_s;
    rank_t         cand_s;
    logic          avail_s;
    logic          accept_s;

    bj_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (SYS_CLK),
        .rst   (GEN_RES),
        .raw   (START),
        .press (start_press_s)
    );

    bj_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_new_card (
        .clk   (SYS_CLK),
        .rst   (GEN_RES),
        .raw   (NEW_CARD),
        .press (new_press_s)
    );

    assign cand_s = lfsr_r[3:0];

    // Is the candidate rank still present in the shoe?
    always_comb begin
        avail_s = 1'b0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            avail_s = avail_s | ((cand_s == 4'(i)) && (cnt_r[i] != 3'd0));
        end
    end

    assign accept_s = (state_r == ST_DRAW) && (cand_s < 4'(NUM_RANKS)) && avail_s;

    // Next state; a START press preempts every other transition.
    always_comb begin
        state_s = state_r;
        if (start_press_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (new_press_s) state_s = ST_DRAW;
                    else             state_s = ST_IDLE;
                end
                ST_DRAW: begin
                    if (accept_s) state_s = ST_PRESENT;
                    else          state_s = ST_DRAW;
                end
                ST_PRESENT: begin
                    if (CARD_READY) state_s = (left_r == 7'd0) ? ST_EMPTY : ST_IDLE;
                    else            state_s = ST_PRESENT;
                end
                ST_EMPTY: state_s = ST_EMPTY;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES) state_r <= ST_IDLE;
        else         state_r <= state_s;
    end

    // Free-running LFSR; its low nibble is the draw candidate.
    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES) lfsr_r <= LFSR_SEED;
        else         lfsr_r <= lfsr_next(lfsr_r);
    end

    // Shoe bookkeeping; a reshuffle also returns any unaccepted card.
    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES || start_press_s) begin
            for (int i = 0; i < NUM_RANKS; i++) cnt_r[i] <= COPIES;
            left_r <= SHOE_SIZE;
        end else if (accept_s) begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                if (cand_s == 4'(i)) cnt_r[i] <= cnt_r[i] - 3'd1;
                else                 cnt_r[i] <= cnt_r[i];
            end
            left_r <= left_r - 7'd1;
        end else begin
            left_r <= left_r;
        end
    end

    // Drawn card, held stable while presented.
    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES) begin
            rank_r <= 4'd0;
            val_r  <= 4'd0;
        end else if (accept_s) begin
            rank_r <= cand_s;
            val_r  <= card_value(cand_s);
        end else begin
            rank_r <= rank_r;
            val_r  <= val_r;
        end
    end

    // One-cycle reshuffle indication.
    always_ff @(posedge SYS_CLK) begin
        if (GEN_RES) shuffled_r <= 1'b0;
        else         shuffled_r <= start_press_s;
    end

    assign CARD_VALID = (state_r == ST_PRESENT);
    assign DECK_EMPTY = (state_r == ST_EMPTY);
    assign CARD_VAL   = val_r;
    assign CARD_RANK  = rank_r;
    assign CARDS_LEFT = left_r;
    assign SHUFFLED   = shuffled_r;

endmodule

// File: doc/bj_card_dealer.md
Name: bj_card_dealer

Overview:
Upstream feeder for the blackjack game FSM. It debounces the raw active-low START and NEW_CARD pushbuttons and tracks a finite shoe of cards per rank. On each NEW_CARD press it draws a pseudo-random card from the remaining shoe and presents it to the game FSM over a valid/ready handshake. A START press reshuffles the shoe.

Parameters:
DEB_CYCLES, 4, consecutive stable samples required before a debounced level changes (range 1..255)
DECK_COPIES, 4, cards per rank in a full shoe (range 1..7; shoe size = 13*DECK_COPIES)
LFSR_SEED, 8'hA5, reset value of the 8-bit LFSR (must be nonzero)

Ports:
SYS_CLK  in  1  system clock; all logic on rising edge
GEN_RES  in  1  synchronous, active-high reset
START  in  1  raw pushbutton, active low, asynchronous to SYS_CLK
NEW_CARD  in  1  raw pushbutton, active low, asynchronous to SYS_CLK
CARD_READY  in  1  game FSM accepts the presented card
CARD_VALID  out  1  card presented on CARD_VAL/CARD_RANK
CARD_VAL  out  4  blackjack value 1..10 (ace = 1)
CARD_RANK  out  4  rank 0..12 (0 = A, 1..9 = 2..10, 10/11/12 = J/Q/K)
CARDS_LEFT  out  7  cards remaining in the shoe
DECK_EMPTY  out  1  shoe exhausted
SHUFFLED  out  1  one-cycle pulse after a START-triggered reshuffle

Behaviour:
- Reset (GEN_RES = 1 at an edge):
  - Outputs: CARD_VALID = 0, CARD_VAL = 0, CARD_RANK = 0, CARDS_LEFT = 13*DECK_COPIES, DECK_EMPTY = 0, SHUFFLED = 0.
  - Internal: per-rank counts = DECK_COPIES, LFSR = LFSR_SEED, synchronisers and debounced levels = 1 (released), state = IDLE.
  - Reset overrides everything, including mid-DRAW or mid-PRESENT; the pending card is discarded.
- Input conditioning, per button:
  - 2-FF synchroniser.
  - The debounced level takes the synchronised value once that value has differed from the current level for DEB_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every cycle when not in reset. Candidate rank = LFSR[3:0].
- States: IDLE, DRAW, PRESENT, EMPTY.
- IDLE:
  - NEW_CARD event -> DRAW.
- DRAW, one candidate evaluated per cycle:
  - Candidate accepted when candidate < 13 and count[candidate] != 0.
  - On accept: count[candidate] decrements, CARDS_LEFT decrements, CARD_RANK/CARD_VAL are registered, -> PRESENT.
  - On reject: stay in DRAW.
  - Maximal LFSR period bounds the retries to 255 cycles.
  - Minimum latency is 2 cycles from the press-event cycle to CARD_VALID = 1.
- PRESENT:
  - CARD_VALID = 1. CARD_VAL and CARD_RANK are stable until handshake.
  - On an edge with CARD_READY = 1: CARD_VALID = 0 next cycle, then -> EMPTY if CARDS_LEFT == 0, else IDLE.
- EMPTY:
  - DECK_EMPTY = 1. NEW_CARD events are ignored.
- NEW_CARD events in DRAW or PRESENT are dropped. There is no queueing.
- START event, in any state:
  - All counts reload to DECK_COPIES, CARDS_LEFT reloads, CARD_VALID = 0, DECK_EMPTY = 0, state -> IDLE.
  - SHUFFLED = 1 for exactly the following cycle.
  - A card in PRESENT that was not yet accepted is returned to the shoe by the reload.
- Simultaneous START and NEW_CARD events in the same cycle: START wins, NEW_CARD is dropped.
- CARD_READY while not in PRESENT is ignored.
- Value mapping: rank 0 -> 1; rank r in 1..9 -> r+1; ranks 10..12 -> 10.

Decomposition:
- Package bj_pkg:
  - NUM_RANKS = 13
  - rank typedef (4-bit)
  - card-value function (rank -> value)
  - dealer state enum
  - LFSR tap constant
- Sub-module bj_debounce (synchroniser + stability counter + falling-edge pulse, parameter DEB_CYCLES), instantiated once each for START and NEW_CARD.

Test Plan:
1. GEN_RES high 2 cycles -> CARD_VALID = 0, CARDS_LEFT = 52, DECK_EMPTY = 0, SHUFFLED = 0; NEW_CARD held high 20 cycles -> no CARD_VALID.
2. Bounce: NEW_CARD low 2 cycles, high 2, low 2, then high -> no draw. NEW_CARD low 10 cycles -> exactly one CARD_VALID. With CARD_READY = 1 it lasts 1 cycle and CARDS_LEFT = 51.
3. Handshake: CARD_READY = 0 for 5 cycles while CARD_VALID = 1 -> CARD_VAL/CARD_RANK stable, second NEW_CARD press dropped. CARD_READY = 1 -> CARD_VALID = 0 next cycle, CARDS_LEFT = 51. Rank/value pairs match the bj_pkg mapping and a bit-exact LFSR model.
4. Exhaustion with DECK_COPIES = 1: 13 presses, each accepted -> ranks 0..12 each seen exactly once, CARDS_LEFT 12..0, DECK_EMPTY = 1 after the 13th accept. 14th press -> no CARD_VALID.
5. START press while in PRESENT with CARD_READY = 0 -> CARD_VALID = 0, CARDS_LEFT = 52, SHUFFLED pulse of 1 cycle, state IDLE. The next NEW_CARD press draws normally.
6. Start/reset collisions:
   - START and NEW_CARD debounced events on the same cycle -> shuffle only, no CARD_VALID.
   - GEN_RES asserted mid-DRAW -> all reset values, LFSR = 8'hA5.
